// File: rtl/tx_buf_datapath.sv
// Transmit-buffer datapath slice: 74161-style 4-bit counter (byte timing),
// 74244-style dual-nibble bus buffer and an asynchronous byte-wide SRAM.
module tx_buf_datapath #(
  parameter int         A_WIDTH       = 11,
  parameter logic [7:0] INITIAL_VALUE = 8'd38
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               enp,
  input  logic               ent,
  input  logic               load_n,
  input  logic [3:0]         p,
  output logic [3:0]         q,
  output logic               rco,
  input  logic [7:0]         buf_i,
  input  logic               n_oe1,
  input  logic               n_oe2,
  input  logic [A_WIDTH-1:0] a,
  inout  wire  [7:0]         d,
  input  logic               n_cs,
  input  logic               n_oe,
  input  logic               n_we
);

  localparam int DEPTH = 2 ** A_WIDTH;

  // ---------------------------------------------------------------- counter
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= 4'h0;
    end else if (!load_n) begin
      q <= p;
    end else if (enp && ent) begin
      q <= q + 4'h1;
    end
  end

  // Carry is gated by ent only, so cascaded stages can stall the byte clock.
  assign rco = ent && (q == 4'hF);

  // ----------------------------------------------------------------- buffer
  assign d[3:0] = !n_oe1 ? buf_i[3:0] : 4'bz;
  assign d[7:4] = !n_oe2 ? buf_i[7:4] : 4'bz;

  // -------------------------------------------------------------------- RAM
  // NOTE: the array is deliberately not cleared by clr_n; its power-up
  // content comes from the declaration and only the bus ever changes it.
  logic [7:0] mem [DEPTH] = '{default: INITIAL_VALUE};

  logic ram_write;
  logic ram_read;

  assign ram_write = !n_cs && !n_we;
  // A low n_we masks the output so a write never fights its own read.
  assign ram_read  = !n_cs && !n_oe && n_we;

  // NOTE: the write port is intentionally transparent (a latch, not a flop):
  // while enabled, the addressed byte tracks the bus and holds on release.
  always_latch begin
    if (ram_write) begin
      mem[a] <= d;
    end
  end

  assign d = ram_read ? mem[a] : 8'bz;

endmodule

// File: tb/tb_tx_buf_datapath.sv
// Self-checking bench for tx_buf_datapath: directed scenarios plus randomized
// counter and RAM traffic compared against a behavioural model.
module tb_tx_buf_datapath;

  localparam int         A_WIDTH = 11;
  localparam int         DEPTH   = 2 ** A_WIDTH;
  localparam logic [7:0] INIT    = 8'h26;

  logic               clk = 1'b0;
  logic               clr_n;
  logic               enp, ent, load_n;
  logic [3:0]         p;
  logic [3:0]         q;
  logic               rco;
  logic [7:0]         buf_i;
  logic               n_oe1, n_oe2;
  logic [A_WIDTH-1:0] a;
  wire  [7:0]         d;
  logic               n_cs, n_oe, n_we;

  // External bus agent, one enable per nibble.
  logic [7:0] ext_d;
  logic       ext_lo_en, ext_hi_en;
  assign d[3:0] = ext_lo_en ? ext_d[3:0] : 4'bz;
  assign d[7:4] = ext_hi_en ? ext_d[7:4] : 4'bz;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] model_mem [DEPTH];

  tx_buf_datapath #(.A_WIDTH(A_WIDTH), .INITIAL_VALUE(INIT)) dut (
    .clk(clk), .clr_n(clr_n), .enp(enp), .ent(ent), .load_n(load_n), .p(p),
    .q(q), .rco(rco), .buf_i(buf_i), .n_oe1(n_oe1), .n_oe2(n_oe2), .a(a),
    .d(d), .n_cs(n_cs), .n_oe(n_oe), .n_we(n_we)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string name, input logic [3:0] exp_q, input logic exp_rco);
    tests_run++;
    if (q !== exp_q || rco !== exp_rco) begin
      tests_failed++;
      $display("FAIL %s: q=%h rco=%b, expected q=%h rco=%b", name, q, rco, exp_q, exp_rco);
    end
  endtask

  task automatic check_d(input string name, input logic [7:0] exp_d);
    tests_run++;
    if (d !== exp_d) begin
      tests_failed++;
      $display("FAIL %s: d=%h, expected %h", name, d, exp_d);
    end
  endtask

  task automatic ram_write(input logic [A_WIDTH-1:0] addr, input logic [7:0] data);
    n_oe = 1'b1; n_oe1 = 1'b0; n_oe2 = 1'b0; buf_i = data; a = addr; n_cs = 1'b0;
    #2 n_we = 1'b0;
    #3 n_we = 1'b1;
    #1 n_oe1 = 1'b1; n_oe2 = 1'b1; n_cs = 1'b1;
    model_mem[addr] = data;
    #1;
  endtask

  task automatic ram_read_check(input string name, input logic [A_WIDTH-1:0] addr);
    n_oe1 = 1'b1; n_oe2 = 1'b1; n_we = 1'b1; a = addr; n_cs = 1'b0; n_oe = 1'b0;
    #2 check_d(name, model_mem[addr]);
    n_oe = 1'b1; n_cs = 1'b1;
    #1;
  endtask

  // ------------------------------------------------------------- counter
  task automatic test_reset();
    #3 check_q("reset_held", 4'h0, 1'b0);
    @(negedge clk);
    clr_n = 1'b1; enp = 1'b1; ent = 1'b1; load_n = 1'b1;
    repeat (9) step();
    check_q("count_to_9", 4'h9, 1'b0);
    #1 clr_n = 1'b0;
    #1 check_q("async_clear", 4'h0, 1'b0);
    @(negedge clk);
    check_q("clear_held_over_edge", 4'h0, 1'b0);
  endtask

  task automatic test_free_run();
    clr_n = 1'b1; enp = 1'b1; ent = 1'b1; load_n = 1'b1;
    #1 check_q("free_run_start", 4'h0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      step();
      check_q($sformatf("free_run_%0d", i), 4'((i % 16)), (i % 16) == 15);
    end
  endtask

  task automatic test_load_hold();
    load_n = 1'b0; p = 4'hC;
    step();
    check_q("load_c", 4'hC, 1'b0);
    load_n = 1'b1; ent = 1'b0; enp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_q("hold_ent_low", 4'hC, 1'b0);
    end
    ent = 1'b1;
    for (int i = 13; i <= 15; i++) begin
      step();
      check_q($sformatf("count_%0d", i), 4'(i), i == 15);
    end
    ent = 1'b0;
    #1 check_q("rco_gated_by_ent", 4'hF, 1'b0);
    ent = 1'b1;
    step();
    check_q("wrap_after_load", 4'h0, 1'b0);
  endtask

  task automatic test_counter_random();
    int model_q = 0;
    clr_n = 1'b0;
    #1 clr_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      enp = 1'($urandom); ent = 1'($urandom);
      load_n = ($urandom_range(0, 7) != 0); p = 4'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        clr_n = 1'b0;
        #1 model_q = 0;
        check_q("random_async_clear", 4'h0, 1'b0);
        clr_n = 1'b1;
      end
      #1 check_q("random_rco_comb", 4'(model_q), ent && model_q == 15);
      step();
      if (!load_n)          model_q = p;
      else if (enp && ent)  model_q = (model_q + 1) % 16;
      check_q("random_count", 4'(model_q), ent && model_q == 15);
    end
    enp = 1'b0; ent = 1'b0; load_n = 1'b1;
  endtask

  // ------------------------------------------------------------- RAM/bus
  task automatic test_power_up_read();
    ram_read_check("powerup_a0", '0);
    ram_read_check("powerup_a2047", A_WIDTH'(DEPTH - 1));
  endtask

  task automatic test_buffer_write();
    n_cs = 1'b1; n_oe1 = 1'b0; n_oe2 = 1'b0; buf_i = 8'h5E;
    #1 check_d("buffer_drives", 8'h5E);
    n_oe1 = 1'b1; n_oe2 = 1'b1;
    ram_write(A_WIDTH'('h155), 8'hA5);
    ram_read_check("write_0x155", A_WIDTH'('h155));
    ram_read_check("neighbour_0x154", A_WIDTH'('h154));
  endtask

  task automatic test_split_nibble();
    n_oe = 1'b1; n_oe1 = 1'b0; n_oe2 = 1'b1; buf_i = 8'h3C;
    ext_d = 8'h90; ext_hi_en = 1'b1; a = A_WIDTH'(7); n_cs = 1'b0;
    #2 n_we = 1'b0;
    #1 check_d("split_bus_value", 8'h9C);
    #2 n_we = 1'b1;
    #1 ext_hi_en = 1'b0; n_oe1 = 1'b1; n_cs = 1'b1;
    model_mem[7] = 8'h9C;
    ram_read_check("split_readback", A_WIDTH'(7));
  endtask

  task automatic test_cs_blocked();
    a = A_WIDTH'('h300); n_cs = 1'b1; n_oe = 1'b1;
    n_oe1 = 1'b0; n_oe2 = 1'b0; buf_i = 8'hFF;
    #2 n_we = 1'b0;
    #3 n_we = 1'b1;
    #1 n_oe1 = 1'b1; n_oe2 = 1'b1;
    ram_read_check("cs_blocked_write", A_WIDTH'('h300));
    // With the RAM released, the bus carries only the external agent's value.
    ext_d = 8'h00; ext_lo_en = 1'b1; ext_hi_en = 1'b1;
    a = A_WIDTH'('h155); n_cs = 1'b1; n_oe = 1'b0;
    #1 check_d("release_cs_high", 8'h00);
    n_cs = 1'b0; n_oe = 1'b1;
    #1 check_d("release_oe_high", 8'h00);
    n_oe = 1'b0; n_we = 1'b0; n_cs = 1'b1;
    #1 n_we = 1'b1;
    ext_lo_en = 1'b0; ext_hi_en = 1'b0; n_oe = 1'b1;
    #1;
  endtask

  task automatic test_level_write();
    // Address moves during the write: both bytes take the bus value.
    n_oe = 1'b1; n_oe1 = 1'b0; n_oe2 = 1'b0; buf_i = 8'h77;
    a = A_WIDTH'('h10); n_cs = 1'b0;
    #1 n_we = 1'b0;
    #2 a = A_WIDTH'('h11);
    // Data changes late in the pulse: the last value before release sticks.
    #2 buf_i = 8'h22;
    #2 n_we = 1'b1;
    #1 n_oe1 = 1'b1; n_oe2 = 1'b1; n_cs = 1'b1;
    model_mem['h10] = 8'h77;
    model_mem['h11] = 8'h22;
    ram_read_check("addr_change_first", A_WIDTH'('h10));
    ram_read_check("addr_change_last", A_WIDTH'('h11));
  endtask

  task automatic test_ram_random();
    logic [A_WIDTH-1:0] addr;
    for (int i = 0; i < 80; i++) begin
      addr = A_WIDTH'($urandom_range(0, 15) * 128 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) ram_write(addr, 8'($urandom));
      else                           ram_read_check("random_read", addr);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
    clr_n = 1'b0; enp = 1'b0; ent = 1'b0; load_n = 1'b1; p = 4'h0;
    buf_i = 8'h00; n_oe1 = 1'b1; n_oe2 = 1'b1; a = '0;
    n_cs = 1'b1; n_oe = 1'b1; n_we = 1'b1;
    ext_d = 8'h00; ext_lo_en = 1'b0; ext_hi_en = 1'b0;

    test_reset();
    test_free_run();
    test_load_hold();
    test_counter_random();
    test_power_up_read();
    test_buffer_write();
    test_split_nibble();
    test_cs_blocked();
    test_level_write();
    test_ram_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
